unidade_controle_regras_param: RTL and testbench

//  Parametrised rule sequencer for the fuzzy inference processor; next generation of the fixed 2-input rule control unit.

---
 rtl/unidade_controle_regras_param_if.sv | 45 ++++
 rtl/unidade_controle_regras_param.sv | 152 +++++++++++++++
 tb/tb_unidade_controle_regras_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_regras_param_if.sv
// ---------------------------------------------------------------------------
// unidade_controle_regras_param_if
// Bundle between the rule sequencer and the inference unit.
//   master : sequencer side (drives the rule stream, status and debug state)
//   slave  : inference/host side (drives start request, active-set mask, ready)
// Signals:
//   EN_REGRAS        start request (rising edge starts one evaluation)
//   FOU_ativo        active-set mask, bits [i*N_SETS +: N_SETS] belong to input i
//   rule_ready       inference unit accepts the current rule
//   Sequencia_regras current rule index
//   rule_valid       Sequencia_regras valid
//   rule_active      antecedent of the emitted rule fully active
//   Reset_Inf        1-cycle clear pulse to the inference accumulators
//   busy             evaluation in progress
//   done             1-cycle end-of-evaluation pulse
//   estado           FSM state for debug
// ---------------------------------------------------------------------------
interface unidade_controle_regras_param_if #(
    parameter int N_IN   = 2,
    parameter int N_SETS = 3
);
    localparam int NR = N_SETS ** N_IN;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;

    logic                     EN_REGRAS;
    logic [N_IN*N_SETS-1:0]   FOU_ativo;
    logic                     rule_ready;
    logic [RW-1:0]            Sequencia_regras;
    logic                     rule_valid;
    logic                     rule_active;
    logic                     Reset_Inf;
    logic                     busy;
    logic                     done;
    logic [2:0]               estado;

    modport master (
        input  EN_REGRAS, FOU_ativo, rule_ready,
        output Sequencia_regras, rule_valid, rule_active, Reset_Inf, busy, done, estado
    );

    modport slave (
        output EN_REGRAS, FOU_ativo, rule_ready,
        input  Sequencia_regras, rule_valid, rule_active, Reset_Inf, busy, done, estado
    );
endinterface

// File: rtl/unidade_controle_regras_param.sv
// ---------------------------------------------------------------------------
// unidade_controle_regras_param
// Parametrised rule sequencer for the fuzzy inference processor. On a rising
// edge of EN_REGRAS it pulses Reset_Inf, latches the active-set mask and walks
// every rule index in ascending order, emitting the rules whose antecedent
// sets are all active (or every rule, qualified by rule_active, in full-scan
// mode) over a valid/ready handshake. done pulses once the walk completes.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-low
//   bus  unidade_controle_regras_param_if.master (rule stream, status, debug)
// ---------------------------------------------------------------------------
module unidade_controle_regras_param #(
    parameter int N_IN      = 2,
    parameter int N_SETS    = 3,
    parameter int FULL_SCAN = 0
) (
    input  logic clk,
    input  logic rst,
    unidade_controle_regras_param_if.master bus
);
    localparam int NR = N_SETS ** N_IN;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;
    localparam int DW = $clog2(N_SETS);
    localparam int MW = N_IN * N_SETS;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] SCAN  = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [RW-1:0] LAST_IDX = RW'(NR - 1);
    localparam logic [DW-1:0] LAST_DIG = DW'(N_SETS - 1);

    logic [2:0]        state;
    logic              en_q;
    logic [MW-1:0]     mask;
    // Odometer: one digit per input (selected set), plus the linear rule
    // index kept in step so no multiply is needed to form Sequencia_regras.
    logic [DW-1:0]     digit     [N_IN];
    logic [DW-1:0]     digit_inc [N_IN];
    logic [RW-1:0]     idx;
    logic [RW-1:0]     seq;
    logic              act_q;
    logic              start;
    logic              cand_active;
    logic              emittable;
    logic [N_SETS-1:0] slice;

    assign start     = bus.EN_REGRAS & ~en_q;
    assign emittable = (FULL_SCAN != 0) || cand_active;

    // Candidate is active when every input's selected set is in the mask.
    always_comb begin
        cand_active = 1'b1;
        slice       = '0;
        for (int i = 0; i < N_IN; i++) begin
            slice = mask[i*N_SETS +: N_SETS];
            if (!slice[digit[i]]) begin
                cand_active = 1'b0;
            end
        end
    end

    // Next odometer value: digit 0 increments first, carry ripples upward.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            digit_inc[i] = digit[i];
            if (carry) begin
                if (digit[i] == LAST_DIG) begin
                    digit_inc[i] = '0;
                end else begin
                    digit_inc[i] = digit[i] + 1'b1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            en_q  <= 1'b0;
            mask  <= '0;
            idx   <= '0;
            seq   <= '0;
            act_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                digit[i] <= '0;
            end
        end else begin
            en_q <= bus.EN_REGRAS;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Mask frozen here for the whole walk.
                    mask  <= bus.FOU_ativo;
                    idx   <= '0;
                    for (int i = 0; i < N_IN; i++) begin
                        digit[i] <= '0;
                    end
                    state <= SCAN;
                end
                SCAN: begin
                    if (emittable) begin
                        seq   <= idx;
                        act_q <= cand_active;
                        state <= EMIT;
                    end else if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        digit <= digit_inc;
                    end
                end
                EMIT: begin
                    if (bus.rule_ready) begin
                        digit <= digit_inc;
                        if (seq == LAST_IDX) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Sequencia_regras = seq;
    assign bus.rule_valid       = (state == EMIT);
    assign bus.rule_active      = act_q;
    assign bus.Reset_Inf        = (state == CLEAR);
    assign bus.busy             = (state != IDLE);
    assign bus.done             = (state == DONE);
    assign bus.estado           = state;
endmodule

// File: tb/tb_unidade_controle_regras_param.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_regras_param
// Bench for the rule sequencer with N_IN=2, N_SETS=3, one instance in
// skip-inactive mode and one in full-scan mode. Vector table, hand-written
// corner sequences and randomised masks checked against a reference model.
// ---------------------------------------------------------------------------
module tb_unidade_controle_regras_param;
    localparam int N_IN   = 2;
    localparam int N_SETS = 3;
    localparam int NR     = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic [5:0] fou = '0;
    logic       rdy = 1'b0;
    int         sel = 0;

    always #5 clk = ~clk;

    unidade_controle_regras_param_if #(.N_IN(N_IN), .N_SETS(N_SETS)) bus0 ();
    unidade_controle_regras_param_if #(.N_IN(N_IN), .N_SETS(N_SETS)) bus1 ();

    assign bus0.EN_REGRAS  = en0;
    assign bus0.FOU_ativo  = fou;
    assign bus0.rule_ready = rdy;
    assign bus1.EN_REGRAS  = en1;
    assign bus1.FOU_ativo  = fou;
    assign bus1.rule_ready = rdy;

    unidade_controle_regras_param #(.N_IN(N_IN), .N_SETS(N_SETS), .FULL_SCAN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    unidade_controle_regras_param #(.N_IN(N_IN), .N_SETS(N_SETS), .FULL_SCAN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    logic       o_valid, o_active, o_reset, o_busy, o_done;
    logic [3:0] o_seq;
    logic [2:0] o_est;

    always_comb begin
        if (sel == 0) begin
            o_valid = bus0.rule_valid;  o_active = bus0.rule_active;
            o_reset = bus0.Reset_Inf;   o_busy   = bus0.busy;
            o_done  = bus0.done;        o_seq    = bus0.Sequencia_regras;
            o_est   = bus0.estado;
        end else begin
            o_valid = bus1.rule_valid;  o_active = bus1.rule_active;
            o_reset = bus1.Reset_Inf;   o_busy   = bus1.busy;
            o_done  = bus1.done;        o_seq    = bus1.Sequencia_regras;
            o_est   = bus1.estado;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: rule r selects set (r / N_SETS**i) % N_SETS on input i.
    function automatic bit model_active(input logic [5:0] m, input int r);
        int v;
        int d;
        bit a;
        v = r;
        a = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            d = v % N_SETS;
            v = v / N_SETS;
            if (!m[i*N_SETS + d]) a = 1'b0;
        end
        return a;
    endfunction

    function automatic logic [8:0] model_bitmap(input logic [5:0] m);
        logic [8:0] b;
        b = '0;
        for (int r = 0; r < NR; r++) b[r] = model_active(m, r);
        return b;
    endfunction

    task automatic set_en(input int s, input logic v);
        if (s == 0) en0 = v; else en1 = v;
    endtask

    // One full evaluation. n counts negedges after the start request;
    // Reset_Inf expected at n=1, done at n = 11 + rules emitted + stall cycles.
    task automatic run_eval(input int s, input logic [5:0] m, input int rmode, input bit disturb,
                            input logic [8:0] exp_emit, input logic [8:0] exp_act, input string tag);
        logic [8:0] emit_bm;
        logic [8:0] act_bm;
        logic [3:0] prev_seq;
        int last, n_done, done_at, n_rst, rst_bad, viol, stalls, busy_bad, extra;
        bit prev_valid, prev_acc, acc;
        emit_bm = '0; act_bm = '0; prev_seq = '0;
        last = -1; n_done = 0; done_at = -1; n_rst = 0; rst_bad = 0;
        viol = 0; stalls = 0; busy_bad = 0; extra = 0;
        prev_valid = 1'b0; prev_acc = 1'b0;
        sel = s;
        @(negedge clk);
        fou = m;
        rdy = 1'b0;
        set_en(s, 1'b1);
        for (int n = 1; n <= 300 && n_done == 0; n++) begin
            @(negedge clk);
            if (n == 3) set_en(s, 1'b0);
            if (disturb && n == 5) begin fou = ~m; set_en(s, 1'b1); end
            if (disturb && n == 7) set_en(s, 1'b0);
            if (o_reset === 1'b1) begin n_rst++; if (n != 1) rst_bad++; end
            if (o_busy !== 1'b1) busy_bad++;
            rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            acc = (o_valid === 1'b1) && rdy;
            if (o_valid === 1'b1) begin
                if (prev_acc) viol++;
                if (prev_valid && !prev_acc && o_seq !== prev_seq) viol++;
                if ((!prev_valid || prev_acc) && int'(o_seq) <= last) viol++;
                if (int'(o_seq) >= NR) viol++;
                else if (o_active !== ((s == 1) ? model_active(m, int'(o_seq)) : 1'b1)) viol++;
                if (acc && int'(o_seq) < NR) begin
                    emit_bm[o_seq] = 1'b1;
                    act_bm[o_seq]  = o_active;
                    last           = int'(o_seq);
                end
                if (!acc) stalls++;
            end
            prev_valid = (o_valid === 1'b1);
            prev_acc   = acc;
            prev_seq   = o_seq;
            if (o_done === 1'b1) begin n_done++; done_at = n; end
        end
        set_en(s, 1'b0);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_est !== 3'd0) extra++;
        end
        check({tag, "_emitted"}, 32'(emit_bm), 32'(exp_emit));
        check({tag, "_active"}, 32'(act_bm), 32'(exp_act));
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_done_cycle"}, done_at, 11 + $countones(exp_emit) + stalls);
        check({tag, "_reset_inf_count"}, n_rst, 1);
        check({tag, "_reset_inf_timing"}, rst_bad, 0);
        check({tag, "_handshake"}, viol, 0);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_idle_after"}, extra, 0);
    endtask

    typedef struct {
        int         full;
        logic [5:0] mask;
        int         rmode;
        bit         disturb;
        logic [8:0] emit;
        logic [8:0] act;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int         got;
        int         hold_bad;
        int         dn;
        bit         found;
        int         s;
        logic [5:0] m;

        tbl[0] = '{0, 6'b011_011, 0, 1'b0, 9'h01B, 9'h01B};
        tbl[1] = '{0, 6'b000_000, 0, 1'b0, 9'h000, 9'h000};
        tbl[2] = '{1, 6'b010_100, 0, 1'b0, 9'h1FF, 9'h020};
        tbl[3] = '{0, 6'b111_111, 0, 1'b0, 9'h1FF, 9'h1FF};
        tbl[4] = '{0, 6'b001_110, 0, 1'b0, 9'h006, 9'h006};
        tbl[5] = '{0, 6'b111_001, 1, 1'b0, 9'h049, 9'h049};
        tbl[6] = '{0, 6'b011_011, 0, 1'b1, 9'h01B, 9'h01B};
        tbl[7] = '{1, 6'b000_000, 1, 1'b0, 9'h1FF, 9'h000};
        tbl[8] = '{0, 6'b000_111, 0, 1'b0, 9'h000, 9'h000};
        tbl[9] = '{0, 6'b100_100, 0, 1'b0, 9'h100, 9'h100};

        #2 rst = 1'b0;
        #1;
        check("reset_outputs_fs0",
              {bus0.Sequencia_regras, bus0.rule_valid, bus0.rule_active, bus0.Reset_Inf,
               bus0.busy, bus0.done, bus0.estado}, 0);
        check("reset_outputs_fs1",
              {bus1.Sequencia_regras, bus1.rule_valid, bus1.rule_active, bus1.Reset_Inf,
               bus1.busy, bus1.done, bus1.estado}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_eval(tbl[v].full, tbl[v].mask, tbl[v].rmode, tbl[v].disturb,
                     tbl[v].emit, tbl[v].act, $sformatf("vec%0d", v));
        end

        // Rule 6 only, held by rule_ready=0 for several cycles.
        sel = 0; rdy = 1'b0; fou = 6'b100_001;
        @(negedge clk);
        en0 = 1'b1;
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) en0 = 1'b0;
            if (o_valid === 1'b1) begin got = n; break; end
        end
        en0 = 1'b0;
        check("stall_first_valid_cycle", got, 9);
        check("stall_first_idx", 32'(o_seq), 6);
        check("stall_first_active", 32'(o_active), 1);
        hold_bad = 0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            if (!(o_valid === 1'b1 && o_seq === 4'd6)) hold_bad++;
        end
        check("stall_hold_stable", hold_bad, 0);
        rdy = 1'b1;
        @(negedge clk);
        check("stall_valid_drop", 32'(o_valid), 0);
        rdy = 1'b0;
        dn = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin dn = k; break; end
        end
        check("stall_done_after_accept", dn, 2);
        repeat (2) @(negedge clk);

        // Reset asserted while rule 3 is pending.
        sel = 0; rdy = 1'b1; fou = 6'b011_011;
        @(negedge clk);
        en0 = 1'b1;
        found = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) en0 = 1'b0;
            if (o_valid === 1'b1 && o_seq === 4'd3) begin rdy = 1'b0; found = 1'b1; break; end
        end
        en0 = 1'b0;
        check("midreset_reached_rule3", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("midreset_outputs_async",
              {bus0.Sequencia_regras, bus0.rule_valid, bus0.rule_active, bus0.Reset_Inf,
               bus0.busy, bus0.done, bus0.estado}, 0);
        @(negedge clk);
        check("midreset_no_done", 32'(o_done), 0);
        rst = 1'b1;
        @(negedge clk);
        run_eval(0, 6'b011_011, 0, 1'b0, 9'h01B, 9'h01B, "after_reset");

        // Randomised masks against the reference model.
        for (int r = 0; r < 12; r++) begin
            s = int'($urandom_range(0, 1));
            m = 6'($urandom_range(0, 63));
            run_eval(s, m, 1, 1'($urandom_range(0, 1)),
                     (s == 1) ? 9'h1FF : model_bitmap(m), model_bitmap(m),
                     $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
